axi_wakeup_ctrl: RTL and testbench

Sequences the AXI5 AWAKEUP signal for a manager-side AXI5 interface with wakeup signalling enabled.
- Raises AWAKEUP ahead of any new AW/AR request, then grants upstream logic permission to issue.
- Tracks outstanding write/read transactions and holds AWAKEUP until all complete, plus an idle hangover.
- Sits between the manager's request logic and the axi_if AW/AR/B/R channels.

---
 rtl/axi_wakeup_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_axi_wakeup_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_wakeup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wakeup_ctrl
//  Purpose  : Sequences the AXI5 AWAKEUP signal on a manager-side interface.
//             Raises AWAKEUP ahead of new AW/AR requests, grants upstream
//             permission to issue once the wake delay expires, tracks
//             outstanding writes/reads and releases AWAKEUP after an idle
//             hangover.
//  Ports    : aclk, aresetn (sync, active-low)
//             req_i                  - upstream request pending
//             awvalid/awready, arvalid/arready, bvalid/bready,
//             rvalid/rready/rlast    - channel observation
//             acwakeup               - snoop wake (AXI_WAKEUP_ACWAKEUP_EN only)
//             awakeup                - registered AWAKEUP
//             allow_o                - upstream may raise AWVALID/ARVALID
//             wr_out_o / rd_out_o    - outstanding write / read counts
//             err_o                  - sticky protocol error
//  Options  : `define AXI_WAKEUP_ACWAKEUP_EN adds the acwakeup input.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_wakeup_ctrl #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int WAKE_DELAY      = 2,
  parameter int IDLE_HOLD       = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 req_i,
  input  logic                 awvalid,
  input  logic                 awready,
  input  logic                 arvalid,
  input  logic                 arready,
  input  logic                 bvalid,
  input  logic                 bready,
  input  logic                 rvalid,
  input  logic                 rready,
  input  logic                 rlast,
`ifdef AXI_WAKEUP_ACWAKEUP_EN
  input  logic                 acwakeup,
`endif
  output logic                 awakeup,
  output logic                 allow_o,
  output logic [CNT_WIDTH-1:0] wr_out_o,
  output logic [CNT_WIDTH-1:0] rd_out_o,
  output logic                 err_o
);

  localparam int TMR_MAX = (WAKE_DELAY > IDLE_HOLD) ? WAKE_DELAY : IDLE_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  generate
    if (WAKE_DELAY < 1) begin : g_bad_wake_delay
      $error("axi_wakeup_ctrl: WAKE_DELAY must be >= 1");
    end
    if (IDLE_HOLD < 1) begin : g_bad_idle_hold
      $error("axi_wakeup_ctrl: IDLE_HOLD must be >= 1");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
      $error("axi_wakeup_ctrl: MAX_OUTSTANDING must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_WAKING = 2'd1,
    ST_AWAKE  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic [TMR_W-1:0]     r_wake_tmr, w_wake_tmr_nxt;
  logic [TMR_W-1:0]     r_hold_tmr, w_hold_tmr_nxt;
  logic [CNT_WIDTH-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic                 r_awakeup;
  logic                 r_err;
  logic                 w_err_set;
  logic                 w_wake_req;
  logic                 w_any_valid;
  logic                 w_idle;
  logic                 w_full;
  logic                 w_allow;

  // Snoop wake behaves like an upstream request for both wake-up and idle.
`ifdef AXI_WAKEUP_ACWAKEUP_EN
  assign w_wake_req = req_i | acwakeup;
`else
  assign w_wake_req = req_i;
`endif

  assign w_any_valid = awvalid | arvalid;
  assign w_full      = (r_wr_cnt == C_MAX) || (r_rd_cnt == C_MAX);
  // Idle uses the counts before this cycle's handshakes are applied.
  assign w_idle      = !w_wake_req && !w_any_valid &&
                       (r_wr_cnt == '0) && (r_rd_cnt == '0);

  // Outstanding counters saturate at both ends; any saturation is an error.
  always_comb begin
    logic w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;
    w_wr_inc     = awvalid & awready;
    w_wr_dec     = bvalid & bready;
    w_rd_inc     = arvalid & arready;
    w_rd_dec     = rvalid & rready & rlast;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    // A VALID while AWAKEUP is low means upstream ignored allow_o.
    w_err_set    = w_any_valid & ~r_awakeup;

    if (w_wr_inc && !w_wr_dec) begin
      if (r_wr_cnt == C_MAX) w_err_set = 1'b1;
      else                   w_wr_cnt_nxt = r_wr_cnt + 1'b1;
    end else if (w_wr_dec && !w_wr_inc) begin
      if (r_wr_cnt == '0)    w_err_set = 1'b1;
      else                   w_wr_cnt_nxt = r_wr_cnt - 1'b1;
    end

    if (w_rd_inc && !w_rd_dec) begin
      if (r_rd_cnt == C_MAX) w_err_set = 1'b1;
      else                   w_rd_cnt_nxt = r_rd_cnt + 1'b1;
    end else if (w_rd_dec && !w_rd_inc) begin
      if (r_rd_cnt == '0)    w_err_set = 1'b1;
      else                   w_rd_cnt_nxt = r_rd_cnt - 1'b1;
    end
  end

  // Next-state and allow logic.
  always_comb begin
    w_next         = r_state;
    w_wake_tmr_nxt = r_wake_tmr;
    w_hold_tmr_nxt = r_hold_tmr;
    w_allow        = 1'b0;
    case (r_state)
      ST_SLEEP: begin
        // A stray VALID skips the wake delay: the request is already out.
        if (w_any_valid) begin
          w_next = ST_AWAKE;
        end else if (w_wake_req) begin
          w_next         = ST_WAKING;
          w_wake_tmr_nxt = TMR_W'(WAKE_DELAY - 1);
        end
      end
      ST_WAKING: begin
        if (r_wake_tmr == '0) w_next = ST_AWAKE;
        else                  w_wake_tmr_nxt = r_wake_tmr - 1'b1;
      end
      ST_AWAKE: begin
        w_allow = ~w_full;
        if (w_idle) begin
          w_next         = ST_HOLD;
          w_hold_tmr_nxt = TMR_W'(IDLE_HOLD - 1);
        end
      end
      ST_HOLD: begin
        w_allow = 1'b1;
        if (!w_idle)                w_next = ST_AWAKE;
        else if (r_hold_tmr == '0)  w_next = ST_SLEEP;
        else                        w_hold_tmr_nxt = r_hold_tmr - 1'b1;
      end
      default: w_next = ST_SLEEP;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= ST_SLEEP;
      r_wake_tmr <= '0;
      r_hold_tmr <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_awakeup  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wake_tmr <= w_wake_tmr_nxt;
      r_hold_tmr <= w_hold_tmr_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      // Every state except SLEEP drives AWAKEUP high.
      r_awakeup  <= (w_next != ST_SLEEP);
      r_err      <= r_err | w_err_set;
    end
  end

  assign awakeup  = r_awakeup;
  assign allow_o  = w_allow;
  assign wr_out_o = r_wr_cnt;
  assign rd_out_o = r_rd_cnt;
  assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_wakeup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_wakeup_ctrl
//  Purpose  : Self-checking bench for axi_wakeup_ctrl (default parameters:
//             MAX_OUTSTANDING=8, WAKE_DELAY=2, IDLE_HOLD=4). A vector table
//             walks one long operational sequence; short hand sequences
//             cover reset mid-wake, stray VALID while asleep and counter
//             saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wakeup_ctrl;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       req_i, awvalid, awready, arvalid, arready;
  logic       bvalid, bready, rvalid, rready, rlast;
  logic       awakeup, allow_o, err_o;
  logic [3:0] wr_out_o, rd_out_o;
`ifdef AXI_WAKEUP_ACWAKEUP_EN
  logic       acwakeup = 1'b0;
`endif

  axi_wakeup_ctrl dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req_i    (req_i),
    .awvalid  (awvalid),
    .awready  (awready),
    .arvalid  (arvalid),
    .arready  (arready),
    .bvalid   (bvalid),
    .bready   (bready),
    .rvalid   (rvalid),
    .rready   (rready),
    .rlast    (rlast),
`ifdef AXI_WAKEUP_ACWAKEUP_EN
    .acwakeup (acwakeup),
`endif
    .awakeup  (awakeup),
    .allow_o  (allow_o),
    .wr_out_o (wr_out_o),
    .rd_out_o (rd_out_o),
    .err_o    (err_o)
  );

  always #5 aclk = ~aclk;

  // Input bit order: {req, awv, awr, arv, arr, bv, br, rv, rr, rlast}
  localparam logic [9:0] c_NONE = 10'b0000000000;
  localparam logic [9:0] c_REQ  = 10'b1000000000;
  localparam logic [9:0] c_AWV  = 10'b0100000000;
  localparam logic [9:0] c_AW   = 10'b0110000000;
  localparam logic [9:0] c_ARV  = 10'b0001000000;
  localparam logic [9:0] c_AR   = 10'b0001100000;
  localparam logic [9:0] c_B    = 10'b0000011000;
  localparam logic [9:0] c_RB   = 10'b0000000110;
  localparam logic [9:0] c_RL   = 10'b0000000111;

  // Expected bit order: {awakeup, allow_o, wr[3:0], rd[3:0], err}
  typedef struct packed {
    logic [9:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [10:0] ex(input logic aw, input logic al,
                                     input int wr, input int rd,
                                     input logic er);
    return {aw, al, 4'(wr), 4'(rd), er};
  endfunction

  task automatic add(input logic [9:0] in, input logic [10:0] e);
    vec_t v;
    v.in  = in;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [9:0] in);
    {req_i, awvalid, awready, arvalid, arready,
     bvalid, bready, rvalid, rready, rlast} = in;
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [9:0] in);
    drive(in);
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [10:0] e);
    logic [10:0] act;
    act = {awakeup, allow_o, wr_out_o, rd_out_o, err_o};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got {aw,al,wr,rd,err}=%b required %b", nm, act, e);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step(c_NONE);
    step(c_NONE);
    check("reset_state", ex(0, 0, 0, 0, 0));
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    drive(c_NONE);

    // ---- build main vector table ----
    add(c_NONE, ex(0, 0, 0, 0, 0));             // asleep
    add(c_REQ,  ex(1, 0, 0, 0, 0));             // WAKING, awakeup up
    add(c_REQ,  ex(1, 0, 0, 0, 0));             // wake delay
    add(c_REQ,  ex(1, 1, 0, 0, 0));             // AWAKE, allow up
    for (int i = 1; i <= 7; i++)
      add(c_REQ | c_AW, ex(1, 1, i, 0, 0));
    add(c_REQ | c_AW, ex(1, 0, 8, 0, 0));       // full: allow drops
    add(c_REQ,        ex(1, 0, 8, 0, 0));
    add(c_REQ | c_B,  ex(1, 1, 7, 0, 0));       // one B frees a slot
    add(c_REQ | c_AW | c_B, ex(1, 1, 7, 0, 0)); // simultaneous inc/dec
    for (int i = 6; i >= 0; i--)
      add(c_REQ | c_B, ex(1, 1, i, 0, 0));
    add(c_REQ | c_AR, ex(1, 1, 0, 1, 0));
    add(c_REQ | c_RB, ex(1, 1, 0, 1, 0));       // non-last beats
    add(c_REQ | c_RB, ex(1, 1, 0, 1, 0));
    add(c_RL,         ex(1, 1, 0, 0, 0));       // last beat, req drops
    for (int i = 0; i < 4; i++)
      add(c_NONE, ex(1, 1, 0, 0, 0));           // idle -> HOLD countdown
    add(c_NONE, ex(0, 0, 0, 0, 0));             // 5th idle edge: sleep
    add(c_B,    ex(0, 0, 0, 0, 1));             // B underflow: error
    add(c_NONE, ex(0, 0, 0, 0, 1));             // sticky
    add(c_AWV,  ex(1, 1, 0, 0, 1));             // stray VALID: AWAKE directly
    add(c_AW,   ex(1, 1, 1, 0, 1));
    add(c_B,    ex(1, 1, 0, 0, 1));             // pre-update count nonzero
    add(c_NONE, ex(1, 1, 0, 0, 1));             // -> HOLD (timer 3)
    add(c_NONE, ex(1, 1, 0, 0, 1));             // timer 2
    add(c_REQ,  ex(1, 1, 0, 0, 1));             // back to AWAKE
    for (int i = 0; i < 4; i++)
      add(c_NONE, ex(1, 1, 0, 0, 1));           // full hangover reloaded
    add(c_NONE, ex(0, 0, 0, 0, 1));

    // ---- run table ----
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].in);
      check($sformatf("vec%0d", k), tbl[k].exp);
    end

    // ---- reset in the middle of WAKING ----
    do_reset();
    step(c_REQ);
    check("waking_entry", ex(1, 0, 0, 0, 0));
    aresetn = 1'b0;
    step(c_REQ);
    check("reset_mid_waking", ex(0, 0, 0, 0, 0));
    aresetn = 1'b1;

    // ---- stray ARVALID while asleep ----
    do_reset();
    step(c_ARV);
    check("stray_arvalid", ex(1, 1, 0, 0, 1));
    step(c_AR);
    check("stray_ar_handshake", ex(1, 1, 0, 1, 1));

    // ---- write counter saturation at MAX ----
    do_reset();
    step(c_REQ);
    step(c_REQ);
    step(c_REQ);
    check("awake_again", ex(1, 1, 0, 0, 0));
    for (int i = 0; i < 8; i++) step(c_REQ | c_AW);
    check("wr_at_max", ex(1, 0, 8, 0, 0));
    step(c_REQ | c_AW);
    check("wr_overflow", ex(1, 0, 8, 0, 1));
    step(c_NONE);
    check("wr_overflow_sticky", ex(1, 0, 8, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
